// File: rtl/morty_pkg.sv
// -----------------------------------------------------------------------------
// morty_pkg
// Shared definitions for the morty RV32I decode stage:
//   - XLEN (data/PC width, 32 only)
//   - RV32I major opcode constants OP_LUI .. OP_SYSTEM
//   - immediate-format select codes IMM_U .. IMM_CSR, IMM_NONE (ILL_TYPE)
//   - entry_t: one decoded entry as held in the main/skid registers
// Optional feature macro used by the decoder: MORTY_CSR_EN (CSR instructions).
// -----------------------------------------------------------------------------
package morty_pkg;

  localparam int XLEN = 32;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Immediate-format select as consumed by the immediate extender
  localparam logic [2:0] IMM_U    = 3'h0;
  localparam logic [2:0] IMM_I    = 3'h1;
  localparam logic [2:0] IMM_B    = 3'h2;
  localparam logic [2:0] IMM_J    = 3'h3;
  localparam logic [2:0] IMM_S    = 3'h4;
  localparam logic [2:0] IMM_CSR  = 3'h5;
  localparam logic [2:0] IMM_NONE = 3'h7;
  // Format code for "no immediate" (R-type and illegal); extender returns 0
  localparam logic [2:0] ILL_TYPE = IMM_NONE;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      type_imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            illegal;
  } entry_t;

endpackage

// File: rtl/morty_decode_comb.sv
// -----------------------------------------------------------------------------
// morty_decode_comb
// Pure combinational RV32I decode: instruction word + PC -> decoded entry.
// Ports:
//   i_inst   in  32  instruction word
//   i_pc     in  32  PC of i_inst
//   o_entry  out     decoded entry (inst, pc, type_imm, rd, rs1, rs2, illegal)
// Macro MORTY_CSR_EN: when defined, SYSTEM funct3!=000 decodes as CSR access
// (uimm form -> IMM_CSR, register form -> IMM_I); otherwise those are illegal.
// -----------------------------------------------------------------------------
module morty_decode_comb
  import morty_pkg::*;
(
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  output entry_t          o_entry
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];

  always_comb begin
    o_entry          = '0;
    o_entry.inst     = i_inst;
    o_entry.pc       = i_pc;
    o_entry.rd       = i_inst[11:7];
    o_entry.rs1      = i_inst[19:15];
    o_entry.rs2      = i_inst[24:20];
    o_entry.type_imm = ILL_TYPE;
    o_entry.illegal  = 1'b1;

    // Every listed opcode ends in 2'b11, so compressed encodings (inst[1:0]
    // != 2'b11) fall through to the illegal default.
    case (w_opcode)
      OP_LUI, OP_AUIPC: begin
        o_entry.type_imm = IMM_U;
        o_entry.illegal  = 1'b0;
      end
      OP_JAL: begin
        o_entry.type_imm = IMM_J;
        o_entry.illegal  = 1'b0;
      end
      OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE: begin
        o_entry.type_imm = IMM_I;
        o_entry.illegal  = 1'b0;
      end
      OP_BRANCH: begin
        o_entry.type_imm = IMM_B;
        o_entry.rd       = 5'd0;   // inst[11:7] carries immediate bits
        o_entry.illegal  = 1'b0;
      end
      OP_STORE: begin
        o_entry.type_imm = IMM_S;
        o_entry.rd       = 5'd0;   // inst[11:7] carries immediate bits
        o_entry.illegal  = 1'b0;
      end
      OP_OP: begin
        o_entry.type_imm = ILL_TYPE;  // legal, but no immediate
        o_entry.illegal  = 1'b0;
      end
      OP_SYSTEM: begin
        if (w_funct3 == 3'b000) begin
          o_entry.type_imm = IMM_I;
          o_entry.illegal  = 1'b0;
        end
`ifdef MORTY_CSR_EN
        else if (w_funct3[2]) begin
          // csrr*i: rs1 field is the zero-extended uimm
          o_entry.type_imm = IMM_CSR;
          o_entry.illegal  = 1'b0;
        end else begin
          o_entry.type_imm = IMM_I;
          o_entry.illegal  = 1'b0;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/morty_inst_decode.sv
// -----------------------------------------------------------------------------
// morty_inst_decode
// RV32I decode stage between fetch and execute with a registered 2-entry skid
// buffer (main + skid register). Full throughput; in_ready is a register output
// so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rst_n (async active-low), flush (drop all held entries)
//   in_valid/in_ready/in_inst/in_pc          fetch side handshake
//   out_valid/out_ready/out_inst/out_pc      execute side handshake
//   out_type_imm, out_rd, out_rs1, out_rs2, out_illegal  decoded fields
// Macro MORTY_CSR_EN: enables CSR instruction decode in morty_decode_comb.
// -----------------------------------------------------------------------------
module morty_inst_decode
  import morty_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_type_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_illegal
);

  entry_t w_dec;
  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;
  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_main_free;

  morty_decode_comb u_decode (
    .i_inst  (in_inst),
    .i_pc    (in_pc),
    .o_entry (w_dec)
  );

  // flush voids both handshakes in the cycle it is asserted
  assign w_in_fire   = in_valid && in_ready && !flush;
  assign w_out_fire  = r_main_valid && out_ready && !flush;
  assign w_main_free = !r_main_valid || w_out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // in_ready was low, so no new word can arrive alongside the drain
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      // main is stalled: park the accepted word in the skid register
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready     = !r_skid_valid;
  assign out_valid    = r_main_valid;
  assign out_inst     = r_main.inst;
  assign out_pc       = r_main.pc;
  assign out_type_imm = r_main.type_imm;
  assign out_rd       = r_main.rd;
  assign out_rs1      = r_main.rs1;
  assign out_rs2      = r_main.rs2;
  assign out_illegal  = r_main.illegal;

endmodule

// File: tb/tb_morty_inst_decode.sv
module tb_morty_inst_decode;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_type_imm;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_illegal;

  int tests_run;
  int tests_failed;

  morty_inst_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_type_imm (out_type_imm),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per delivered entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush)
      $display("[TB] out inst=%08h pc=%08h type=%0d rd=%0d ill=%0b",
               out_inst, out_pc, out_type_imm, out_rd, out_illegal);
  end

  // Advance one clock; inputs change and outputs are observed 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tests_run++; if (out_inst !== 32'h0 || out_pc !== 32'h0 || out_type_imm !== 3'h0 || out_illegal !== 1'b0)
      begin tests_failed++; $display("FAIL reset_data got inst=%08h pc=%08h type=%0d ill=%0b exp all 0", out_inst, out_pc, out_type_imm, out_illegal); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h000000B7; in_pc = 32'h0000_0000;
    step();
    tests_run++; if (out_valid !== 1'b1 || out_inst !== 32'h000000B7 || out_type_imm !== 3'd0 || out_rd !== 5'd1)
      begin tests_failed++; $display("FAIL stream_w0 got v=%0b inst=%08h type=%0d rd=%0d exp v=1 inst=000000b7 type=0 rd=1", out_valid, out_inst, out_type_imm, out_rd); end
    in_inst = 32'h00A00093; in_pc = 32'h0000_0004;
    step();
    tests_run++; if (out_valid !== 1'b1 || out_inst !== 32'h00A00093 || out_type_imm !== 3'd1 || out_rd !== 5'd1 || out_pc !== 32'h4)
      begin tests_failed++; $display("FAIL stream_w1 got v=%0b inst=%08h type=%0d rd=%0d pc=%08h exp v=1 inst=00a00093 type=1 rd=1 pc=4", out_valid, out_inst, out_type_imm, out_rd, out_pc); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready got=%0b exp=1", in_ready); end
    in_inst = 32'hFE000EE3; in_pc = 32'h0000_0008;
    step();
    tests_run++; if (out_valid !== 1'b1 || out_inst !== 32'hFE000EE3 || out_type_imm !== 3'd2 || out_rd !== 5'd0 || out_illegal !== 1'b0)
      begin tests_failed++; $display("FAIL stream_w2 got v=%0b inst=%08h type=%0d rd=%0d ill=%0b exp v=1 inst=fe000ee3 type=2 rd=0 ill=0", out_valid, out_inst, out_type_imm, out_rd, out_illegal); end
    in_valid = 1'b0;
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drain got v=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 32'h0000_0100;
    step();
    tests_run++; if (in_ready !== 1'b1 || out_inst !== 32'h00A00093) begin tests_failed++; $display("FAIL bp_first got rdy=%0b inst=%08h exp rdy=1 inst=00a00093", in_ready, out_inst); end
    in_inst = 32'h00B50533; in_pc = 32'h0000_0104;
    step();
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_skid_full got rdy=%0b exp=0", in_ready); end
    in_valid = 1'b0;
    step();
    tests_run++; if (out_valid !== 1'b1 || out_inst !== 32'h00A00093 || out_pc !== 32'h100 || in_ready !== 1'b0)
      begin tests_failed++; $display("FAIL bp_hold got v=%0b inst=%08h pc=%08h rdy=%0b exp v=1 inst=00a00093 pc=100 rdy=0", out_valid, out_inst, out_pc, in_ready); end
    out_ready = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b1 || out_inst !== 32'h00B50533 || out_pc !== 32'h104 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL bp_release got v=%0b inst=%08h pc=%08h rdy=%0b exp v=1 inst=00b50533 pc=104 rdy=1", out_valid, out_inst, out_pc, in_ready); end
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty got v=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 32'h200;
    step();
    in_inst = 32'h00B50533; in_pc = 32'h204;
    step();
    in_inst = 32'h0000006F; in_pc = 32'h208;
    flush = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL flush_full got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_ghost got v=%0b inst=%08h exp v=0", out_valid, out_inst); end
    // Flush with main full, skid empty, and a word offered while in_ready=1
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 32'h300;
    step();
    in_inst = 32'h0000006F; in_pc = 32'h304; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_main got v=%0b exp=0", out_valid); end
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_drop_offered got v=%0b inst=%08h exp v=0", out_valid, out_inst); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h00000000; in_pc = 32'h400;
    step();
    tests_run++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_type_imm !== 3'd7)
      begin tests_failed++; $display("FAIL ill_zero got v=%0b ill=%0b type=%0d exp v=1 ill=1 type=7", out_valid, out_illegal, out_type_imm); end
    in_inst = 32'h0000007F; in_pc = 32'h404;
    step();
    tests_run++; if (out_illegal !== 1'b1 || out_type_imm !== 3'd7 || out_inst !== 32'h7F)
      begin tests_failed++; $display("FAIL ill_7f got ill=%0b type=%0d inst=%08h exp ill=1 type=7 inst=0000007f", out_illegal, out_type_imm, out_inst); end
    in_inst = 32'h00B50533; in_pc = 32'h408;
    step();
    tests_run++; if (out_illegal !== 1'b0 || out_type_imm !== 3'd7 || out_rd !== 5'd10 || out_rs1 !== 5'd10 || out_rs2 !== 5'd11)
      begin tests_failed++; $display("FAIL add_rtype got ill=%0b type=%0d rd=%0d rs1=%0d rs2=%0d exp ill=0 type=7 rd=10 rs1=10 rs2=11", out_illegal, out_type_imm, out_rd, out_rs1, out_rs2); end
    in_inst = 32'h00C5A423; in_pc = 32'h40C;  // sw a2,8(a1)
    step();
    tests_run++; if (out_illegal !== 1'b0 || out_type_imm !== 3'd4 || out_rd !== 5'd0)
      begin tests_failed++; $display("FAIL store got ill=%0b type=%0d rd=%0d exp ill=0 type=4 rd=0", out_illegal, out_type_imm, out_rd); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_csr();
    logic       exp_ill;
    logic [2:0] exp_type;
`ifdef MORTY_CSR_EN
    exp_ill = 1'b0; exp_type = 3'd5;
`else
    exp_ill = 1'b1; exp_type = 3'd7;
`endif
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h3400D073; in_pc = 32'h500;
    step();
    tests_run++; if (out_illegal !== exp_ill || out_type_imm !== exp_type)
      begin tests_failed++; $display("FAIL csrrwi got ill=%0b type=%0d exp ill=%0b type=%0d", out_illegal, out_type_imm, exp_ill, exp_type); end
    in_inst = 32'h00000073; in_pc = 32'h504;  // ecall
    step();
    tests_run++; if (out_illegal !== 1'b0 || out_type_imm !== 3'd1)
      begin tests_failed++; $display("FAIL ecall got ill=%0b type=%0d exp ill=0 type=1", out_illegal, out_type_imm); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00A00093; in_pc = 32'h600;
    step();
    in_inst = 32'h00B50533; in_pc = 32'h604;
    step();
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
      begin tests_failed++; $display("FAIL rst_prefill got rdy=%0b v=%0b exp rdy=0 v=1", in_ready, out_valid); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL rst_async_ctrl got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); end
    tests_run++; if (out_inst !== 32'h0 || out_pc !== 32'h0 || out_rd !== 5'd0 || out_rs1 !== 5'd0 || out_rs2 !== 5'd0)
      begin tests_failed++; $display("FAIL rst_async_data got inst=%08h pc=%08h rd=%0d rs1=%0d rs2=%0d exp all 0", out_inst, out_pc, out_rd, out_rs1, out_rs2); end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_no_residue got v=%0b inst=%08h exp v=0", out_valid, out_inst); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_illegal();
    test_csr();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
